// File: rtl/ddu_ctrl.sv
// ddu_ctrl: board-side debug/display unit for the multicycle CPU.
//   Drives the CPU's cont/run/ddu_addr from switches and debounced buttons, and
//   shows mem_data or reg_data on an 8-digit multiplexed hex display plus 16 LEDs.
// Ports:
//   clk, rst_n           system clock, async active-low reset
//   cont_sw              raw switch, 1 = continuous run
//   step/inc/dec_btn     raw buttons: single step, ddu_addr +1, ddu_addr -1
//   mem_sel              display source, 1 = mem_data, 0 = reg_data
//   mem_data/reg_data/pc words returned by the CPU
//   cont, run, ddu_addr  to CPU
//   seg, an              active-low segments {g..a} and one-hot digit anodes
//   led                  {ddu_addr[7:0], pc[9:2]}, registered

// Debounce one synchronized button level; emits a one-cycle pulse on each
// accepted rising edge.
module ddu_debounce #(
  parameter int DB_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  output logic pulse
);
  logic [DB_W-1:0] cnt;
  logic            lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      lvl   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (s == lvl) begin
        cnt <= '0;
      end else if (cnt == {DB_W{1'b1}}) begin
        // level held for 2^DB_W cycles: accept it; pulse only on a rise
        lvl   <= s;
        cnt   <= '0;
        pulse <= s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module ddu_ctrl #(
  parameter int DB_W   = 20,
  parameter int SCAN_W = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cont_sw,
  input  logic        step_btn,
  input  logic        inc_btn,
  input  logic        dec_btn,
  input  logic        mem_sel,
  input  logic [31:0] mem_data,
  input  logic [31:0] reg_data,
  input  logic [31:0] pc,
  output logic        cont,
  output logic        run,
  output logic [31:0] ddu_addr,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic [15:0] led
);
  // bit 0 = cont_sw, 1 = step, 2 = inc, 3 = dec
  logic [3:0]        sync1, sync2;
  logic [2:0]        btn_pulse;   // {dec, inc, step}
  logic [7:0]        addr8;
  logic [31:0]       disp;
  logic [SCAN_W-1:0] scan;
  logic [2:0]        k;
  logic [3:0]        nib;
  logic              unused_ok;

  assign unused_ok = ^{pc[31:10], pc[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {dec_btn, inc_btn, step_btn, cont_sw};
      sync2 <= sync1;
    end
  end

  ddu_debounce #(.DB_W(DB_W)) u_db [2:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (sync2[3:1]),
    .pulse (btn_pulse)
  );

  // Switch is not debounced; a step pulse arriving in continuous mode is
  // simply absorbed by the OR, so nothing is queued.
  assign cont = sync2[0];
  assign run  = cont | btn_pulse[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr8 <= '0;
    end else begin
      case (btn_pulse[2:1])
        2'b01:   addr8 <= addr8 + 8'd1;
        2'b10:   addr8 <= addr8 - 8'd1;
        default: addr8 <= addr8;        // none, or inc+dec cancel
      endcase
    end
  end

  assign ddu_addr = {24'd0, addr8};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led  <= '0;
      disp <= '0;
      scan <= '0;
    end else begin
      led  <= {addr8, pc[9:2]};
      disp <= mem_sel ? mem_data : reg_data;
      scan <= scan + 1'b1;
    end
  end

  assign k   = scan[SCAN_W-1 -: 3];
  assign an  = ~(8'd1 << k);
  assign nib = disp[{k, 2'b00} +: 4];

  always_comb begin
    seg = 7'b1111111;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

// File: tb/tb_ddu_ctrl.sv
// tb_ddu_ctrl: self-checking bench for ddu_ctrl with DB_W=2, SCAN_W=6.
module tb_ddu_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cont_sw = 1'b0, step_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0;
  logic        mem_sel = 1'b0;
  logic [31:0] mem_data = '0, reg_data = '0, pc = 32'h0000_0ABC;
  logic        cont, run;
  logic [31:0] ddu_addr;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic [15:0] led;

  int          tests = 0, fails = 0;
  logic [31:0] exp_q[$];
  logic [6:0]  hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  ddu_ctrl #(.DB_W(2), .SCAN_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .cont_sw(cont_sw), .step_btn(step_btn),
    .inc_btn(inc_btn), .dec_btn(dec_btn), .mem_sel(mem_sel),
    .mem_data(mem_data), .reg_data(reg_data), .pc(pc),
    .cont(cont), .run(run), .ddu_addr(ddu_addr), .seg(seg), .an(an), .led(led)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input logic i, input logic d);
    inc_btn = i; dec_btn = d; tick(10);
    inc_btn = 0; dec_btn = 0; tick(10);
  endtask

  task automatic test_reset;
    rst_n = 0; tick(2);
    tests++; if (cont !== 1'b0) begin fails++; $display("FAIL rst_cont: got %b want 0", cont); end
    tests++; if (run !== 1'b0) begin fails++; $display("FAIL rst_run: got %b want 0", run); end
    tests++; if (ddu_addr !== 32'd0) begin fails++; $display("FAIL rst_addr: got %h want 0", ddu_addr); end
    tests++; if (led !== 16'd0) begin fails++; $display("FAIL rst_led: got %h want 0", led); end
    rst_n = 1;
    tests++; if (an !== 8'hFE) begin fails++; $display("FAIL rst_an: got %h want fe", an); end
    tests++; if (seg !== 7'b1000000) begin fails++; $display("FAIL rst_seg: got %b want 1000000", seg); end
    tick(1);
    tests++; if (led !== {8'h00, pc[9:2]}) begin fails++; $display("FAIL rst_led1: got %h want %h", led, {8'h00, pc[9:2]}); end
  endtask

  task automatic test_step;
    int n, first, e;
    exp_q.push_back(1);
    n = 0; first = 0;
    step_btn = 1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (run) begin n++; if (first == 0) first = i; end
    end
    step_btn = 0;
    for (int i = 0; i < 12; i++) begin tick(1); if (run) n++; end
    e = int'(exp_q.pop_front());
    tests++; if (n !== e) begin fails++; $display("FAIL step_count: got %0d want %0d", n, e); end
    tests++; if (first < 6 || first > 8) begin fails++; $display("FAIL step_latency: got %0d want 6..8", first); end
    // 3-cycle glitch must be rejected
    exp_q.push_back(0);
    n = 0;
    step_btn = 1;
    for (int i = 1; i <= 18; i++) begin
      tick(1);
      if (i == 3) step_btn = 0;
      if (run) n++;
    end
    e = int'(exp_q.pop_front());
    tests++; if (n !== e) begin fails++; $display("FAIL glitch_count: got %0d want %0d", n, e); end
  endtask

  task automatic test_cont;
    int first, lows, bad, drop;
    first = 0; lows = 0;
    cont_sw = 1;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (run && first == 0) first = i;
      else if (first != 0 && !run) lows++;
    end
    tests++; if (first !== 2) begin fails++; $display("FAIL cont_latency: got %0d want 2", first); end
    tests++; if (lows !== 0) begin fails++; $display("FAIL cont_steady: got %0d low cycles want 0", lows); end
    lows = 0;
    step_btn = 1;
    for (int i = 0; i < 10; i++) begin tick(1); if (!run) lows++; end
    step_btn = 0;
    for (int i = 0; i < 8; i++) begin tick(1); if (!run) lows++; end
    tests++; if (lows !== 0) begin fails++; $display("FAIL cont_step: got %0d low cycles want 0", lows); end
    bad = 0; drop = 0;
    cont_sw = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (run !== cont) bad++;
      if (!cont && drop == 0) drop = i;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL cont_drop: got %0d cycles run!=cont want 0", bad); end
    tests++; if (drop !== 2) begin fails++; $display("FAIL cont_fall: got %0d want 2", drop); end
    tests++; if (run !== 1'b0) begin fails++; $display("FAIL cont_idle: got %b want 0", run); end
  endtask

  task automatic test_addr;
    logic [1:0]  ops [7] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11}; // {inc,dec}
    logic [7:0]  m;
    logic [31:0] e;
    m = 8'd0;
    for (int i = 0; i < 7; i++) begin
      if (ops[i] == 2'b10) m = m + 8'd1;
      else if (ops[i] == 2'b01) m = m - 8'd1;
      exp_q.push_back({24'd0, m});
      exp_q.push_back({16'd0, m, pc[9:2]});
      press(ops[i][1], ops[i][0]);
      e = exp_q.pop_front();
      tests++; if (ddu_addr !== e) begin fails++; $display("FAIL addr_op%0d: got %h want %h", i, ddu_addr, e); end
      e = exp_q.pop_front();
      tests++; if (led !== e[15:0]) begin fails++; $display("FAIL led_op%0d: got %h want %h", i, led, e[15:0]); end
    end
  endtask

  task automatic test_display;
    int         k, bad, oh_bad;
    logic [7:0] seen;
    mem_sel = 1; mem_data = 32'h89AB_CDEF;
    tick(2);
    bad = 0; oh_bad = 0; seen = '0;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      k = 0;
      if ($countones(~an) != 1) oh_bad++;
      for (int j = 0; j < 8; j++) if (!an[j]) k = j;
      seen[k] = 1'b1;
      if (seg !== hex_tab[mem_data[k*4 +: 4]]) bad++;
      if (an == 8'hFE) begin
        tests++; if (seg !== 7'b0001110) begin fails++; $display("FAIL disp_d0: got %b want 0001110", seg); end
      end
      if (an == 8'h7F) begin
        tests++; if (seg !== 7'b0000000) begin fails++; $display("FAIL disp_d7: got %b want 0000000", seg); end
      end
    end
    tests++; if (oh_bad !== 0) begin fails++; $display("FAIL an_onehot: got %0d bad cycles want 0", oh_bad); end
    tests++; if (seen !== 8'hFF) begin fails++; $display("FAIL an_cover: got %h want ff", seen); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL disp_mem: got %0d bad cycles want 0", bad); end
    mem_sel = 0; reg_data = 32'd0;
    tick(2);
    bad = 0;
    for (int i = 0; i < 64; i++) begin tick(1); if (seg !== 7'b1000000) bad++; end
    tests++; if (bad !== 0) begin fails++; $display("FAIL disp_reg0: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid;
    int n, bad;
    for (int i = 0; i < 64 && an == 8'hFE; i++) tick(1);  // land mid-scan
    step_btn = 1; inc_btn = 1;
    tick(4);
    rst_n = 0; #1;
    tests++; if (cont !== 1'b0 || run !== 1'b0) begin fails++; $display("FAIL mid_ctl: got cont=%b run=%b want 0 0", cont, run); end
    tests++; if (ddu_addr !== 32'd0) begin fails++; $display("FAIL mid_addr: got %h want 0", ddu_addr); end
    tests++; if (an !== 8'hFE || seg !== 7'b1000000) begin fails++; $display("FAIL mid_disp: got an=%h seg=%b want fe 1000000", an, seg); end
    tests++; if (led !== 16'd0) begin fails++; $display("FAIL mid_led: got %h want 0", led); end
    step_btn = 0; inc_btn = 0;
    tick(3);
    rst_n = 1;
    n = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (run) n++;
      if (ddu_addr !== 32'd0) bad++;
    end
    tests++; if (n !== 0) begin fails++; $display("FAIL mid_run: got %0d pulses want 0", n); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL mid_addr_hold: got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    test_reset;
    test_step;
    test_cont;
    test_addr;
    test_display;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ddu_ctrl.md
Name: ddu_ctrl

Overview:
- Debug/display unit for the multicycle CPU; it is the board-side counterpart of the CPU's debug port.
- Drives the CPU's cont, run and ddu_addr inputs from board switches and buttons.
- Takes back mem_data, reg_data and pc, and presents the selected word on an 8-digit multiplexed hex seven-segment display plus 16 LEDs.

Parameters:
- DB_W, 20, debounce counter width; a button must hold its new level for 2^DB_W consecutive cycles before the change is accepted.
- SCAN_W, 18, display refresh counter width; the top 3 bits select the active digit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cont_sw  in  1  raw switch; 1 = continuous run, 0 = single-step
- step_btn  in  1  raw button; one CPU step per press
- inc_btn  in  1  raw button; ddu_addr + 1
- dec_btn  in  1  raw button; ddu_addr - 1
- mem_sel  in  1  display source; 1 = mem_data, 0 = reg_data
- mem_data  in  32  memory word at ddu_addr, from CPU
- reg_data  in  32  register at ddu_addr[4:0], from CPU
- pc  in  32  CPU program counter
- cont  out  1  to CPU; continuous-mode enable
- run  out  1  to CPU; execute enable
- ddu_addr  out  32  to CPU; inspection address
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- an  out  8  digit anodes, active-low, one-hot
- led  out  16  {ddu_addr[7:0], pc[9:2]}, registered

Behaviour:
- Reset (async, rst_n=0): all synchronizers, debounce counters and debounced levels are 0.
  - Reset outputs: cont=0, run=0, ddu_addr=0, led=0, scan counter=0, display latch=0.
  - This gives an=8'b11111110 and seg=7'b1000000.
  - Reset asserted mid-press discards all pending edges.
- Inputs cont_sw, step_btn, inc_btn, dec_btn each pass through a 2-FF synchronizer.
- Debounce (per button), with s = synchronized level and d = debounced level:
  - Counter clears whenever s == d; increments while s != d.
  - When the counter equals 2^DB_W-1 and s != d, d <= s and the counter clears.
  - Rising edge of d produces a registered one-cycle pulse.
  - From a raw rising edge held stable, exactly one pulse occurs, 2^DB_W+2 to 2^DB_W+4 cycles later.
  - Falling edges produce no pulse.
  - A glitch shorter than 2^DB_W cycles produces no pulse.
- cont = synchronized cont_sw (no debounce); latency 2 cycles.
- run:
  - While cont=1, run=1 every cycle.
  - While cont=0, run = step pulse, exactly 1 cycle per press.
  - Step pulses while cont=1 are ignored; no queued step.
  - When cont falls, run is 0 in the same cycle.
- ddu_addr:
  - 8-bit counter, zero-extended; ddu_addr[31:8] is always 0.
  - inc pulse: +1, with 255 wrapping to 0.
  - dec pulse: -1, with 0 wrapping to 255.
  - inc and dec pulses in the same cycle: no change.
  - Update is visible the cycle after the pulse.
- Display latch: disp <= mem_sel ? mem_data : reg_data every cycle (1-cycle latency).
- Scan counter increments every cycle and wraps at 2^SCAN_W.
  - k = cnt[SCAN_W-1:SCAN_W-3].
  - an = ~(1<<k).
  - seg = hex7(disp[4k+3:4k]); digit 0 (an[0]) shows disp[3:0].
- hex7 encodes 0-F active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- led registered each cycle from the current ddu_addr and pc.

Test Plan:
- DB_W=2, SCAN_W=6; release reset -> cont=0, run=0, ddu_addr=0, an=FE, seg=1000000; after 1 cycle led={8'h00, pc[9:2]}.
- cont_sw=0; press step_btn held 20 cycles -> run high for exactly 1 cycle, 6-8 cycles after press; 3-cycle glitch -> no run pulse.
- cont_sw=1 -> run=1 continuously from 2 cycles later; step press ignored; cont_sw=0 -> run drops the same cycle cont drops.
- ddu_addr=0, one dec press -> ddu_addr=255; then one inc press -> 0; four inc presses -> 4; inc and dec raw edges aligned -> ddu_addr unchanged.
- mem_sel=1, mem_data=32'h89AB_CDEF -> over one scan period: an=FE seg=0001110 (F); an=7F seg=0000000 (8); mem_sel=0, reg_data=0 -> every digit shows 1000000.
- rst_n pulsed low mid-debounce and mid-scan -> outputs at reset values immediately; no run or address pulse after release.
